alu_32_arbiter: RTL

Two-port round-robin arbiter and sequencer for the shared multi-cycle `alu_32` unit. It accepts operation requests from two requesters, such as the fetch/decode path and a debug or DMA port. For each accepted request it drives the ALU's operand, control, enable and start (`reset`) pins, then waits for the ALU `done`. The result and extra words return to the originating requester over a valid/ready handshake. A cycle-count watchdog guarantees a response even if the ALU never finishes.

---
 rtl/alu_32_arbiter_if.sv | 59 +++++
 rtl/alu_32_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_32_arbiter_if.sv
// alu_32_arbiter_if
//   Bundles the requester handshakes, the shared response bus and the ALU
//   pin group of the alu_32 arbiter/sequencer.
//   slave  : arbiter view (consumes requests, drives responses and ALU pins)
//   master : environment view (requesters plus the alu_32 unit)
//   Signals:
//     req0/1_valid, req0/1_op1, req0/1_op2, req0/1_control  request inputs
//     req0/1_ready                                          request accept
//     rsp0/1_valid, rsp0/1_ready                            response handshake
//     rsp_result, rsp_extra, rsp_error                      shared response data
//     busy                                                  arbiter not idle
//     alu_op1, alu_op2, alu_control, alu_enable, alu_reset  ALU drive
//     alu_result, alu_extra, alu_done                       ALU outputs
interface alu_32_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [1:0]  req0_control;
    logic [1:0]  req1_control;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_extra;
    logic        rsp_error;
    logic        busy;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [1:0]  alu_control;
    logic        alu_enable;
    logic        alu_reset;
    logic [31:0] alu_result;
    logic [31:0] alu_extra;
    logic        alu_done;

    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        input  req0_control, req1_control, rsp0_ready, rsp1_ready,
        input  alu_result, alu_extra, alu_done,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_extra, rsp_error, busy,
        output alu_op1, alu_op2, alu_control, alu_enable, alu_reset
    );

    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        output req0_control, req1_control, rsp0_ready, rsp1_ready,
        output alu_result, alu_extra, alu_done,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_extra, rsp_error, busy,
        input  alu_op1, alu_op2, alu_control, alu_enable, alu_reset
    );
endinterface

// File: rtl/alu_32_arbiter.sv
// alu_32_arbiter
//   Two-port round-robin arbiter and sequencer for the shared multi-cycle
//   alu_32 unit. Accepts one request at a time, starts the ALU, waits for
//   done (bounded by a watchdog) and returns the result to the originating
//   port over a valid/ready handshake.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-low
//     bus    alu_32_arbiter_if.slave (requests, responses, ALU pins)
//   Parameter:
//     TIMEOUT_CYCLES  WAIT cycles before an error response is forced (1..65535)
module alu_32_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    alu_32_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic        port_id;
    logic [15:0] wd_cnt;
    logic        grant0;
    logic        grant1;
    logic        rsp_take;

    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [1:0]  ctrl_r;
    logic        enable_r;
    logic        start_r;
    logic        busy_r;
    logic        rsp0_v;
    logic        rsp1_v;
    logic [31:0] result_r;
    logic [31:0] extra_r;
    logic        error_r;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant0   = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1   = bus.req1_valid && (!bus.req0_valid || !last_grant);
        rsp_take = port_id ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign bus.req0_ready = reset && (state == IDLE) && grant0;
    assign bus.req1_ready = reset && (state == IDLE) && grant1;

    assign bus.alu_op1     = op1_r;
    assign bus.alu_op2     = op2_r;
    assign bus.alu_control = ctrl_r;
    assign bus.alu_enable  = enable_r;
    assign bus.alu_reset   = start_r;
    assign bus.busy        = busy_r;
    assign bus.rsp0_valid  = rsp0_v;
    assign bus.rsp1_valid  = rsp1_v;
    assign bus.rsp_result  = result_r;
    assign bus.rsp_extra   = extra_r;
    assign bus.rsp_error   = error_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port_id    <= 1'b0;
            wd_cnt     <= '0;
            op1_r      <= '0;
            op2_r      <= '0;
            ctrl_r     <= '0;
            enable_r   <= 1'b0;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            rsp0_v     <= 1'b0;
            rsp1_v     <= 1'b0;
            result_r   <= '0;
            extra_r    <= '0;
            error_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op1_r      <= grant1 ? bus.req1_op1 : bus.req0_op1;
                        op2_r      <= grant1 ? bus.req1_op2 : bus.req0_op2;
                        ctrl_r     <= grant1 ? bus.req1_control : bus.req0_control;
                        port_id    <= grant1;
                        last_grant <= grant1;
                        start_r    <= 1'b1;
                        enable_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    start_r <= 1'b0;
                    wd_cnt  <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (bus.alu_done) begin
                        result_r <= bus.alu_result;
                        extra_r  <= bus.alu_extra;
                        error_r  <= 1'b0;
                        enable_r <= 1'b0;
                        rsp0_v   <= !port_id;
                        rsp1_v   <= port_id;
                        state    <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        result_r <= '0;
                        extra_r  <= '0;
                        error_r  <= 1'b1;
                        enable_r <= 1'b0;
                        rsp0_v   <= !port_id;
                        rsp1_v   <= port_id;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_v <= 1'b0;
                        rsp1_v <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
